gptp_rx_ts_fifo: RTL and testbench

Parametrised successor to the single-entry gPTP RX timestamp store. It sits between the RX frame parser and the gPTP protocol engine. Each message-type channel has its own DEPTH-entry FIFO, so back-to-back frames of one type are no longer serialised through a single global handshake. Dual-timestamp channels (e.g. Pdelay_Resp) store both the receive timestamp and the carried timestamp, and the reader retrieves them with two pops.

---
 rtl/gptp_rx_ts_fifo_if.sv | 31 +++
 rtl/gptp_rx_ts_fifo.sv | 175 +++++++++++++++++
 tb/tb_gptp_rx_ts_fifo.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gptp_rx_ts_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gptp_rx_ts_fifo_if : parser-write / engine-read bus of the RX FIFO   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface gptp_rx_ts_fifo_if #(
  parameter int NCH = 8,
  parameter int TSW = 80
);
  logic           wr_valid;
  logic           wr_ready;
  logic [NCH-1:0] wr_ch;
  logic [TSW-1:0] wr_data1;
  logic [TSW-1:0] wr_data2;
  logic [NCH-1:0] rd_avail;
  logic [NCH-1:0] rd_sel;
  logic           rd_pop;
  logic [TSW-1:0] rd_data;
  logic           rd_second;

  modport master (
    output wr_valid, wr_ch, wr_data1, wr_data2, rd_sel, rd_pop,
    input  wr_ready, rd_avail, rd_data, rd_second
  );

  modport slave (
    input  wr_valid, wr_ch, wr_data1, wr_data2, rd_sel, rd_pop,
    output wr_ready, rd_avail, rd_data, rd_second
  );
endinterface
`default_nettype wire

// File: rtl/gptp_rx_ts_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gptp_rx_ts_fifo : per-message-type gPTP RX timestamp FIFOs           |
// | Optional macro GPTP_RXBUF_OVERWRITE_EN: full channel drops oldest.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gptp_rx_ts_fifo #(
  parameter int             NCH       = 8,
  parameter int             TSW       = 80,
  parameter int             DEPTH     = 4,
  parameter logic [NCH-1:0] DUAL_MASK = 8'h08,
  parameter logic [NCH-1:0] WSEL_MASK = 8'h92,
  localparam int            CW        = $clog2(DEPTH + 1)
) (
  input  wire logic            clk,
  input  wire logic            reset,
  gptp_rx_ts_fifo_if.slave     bus,
  input  wire logic            clr_err,
  output logic [NCH*CW-1:0]    cnt_o,
  output logic                 err_sticky,
  output logic                 drop_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CW-1:0] c_cnt_one  = CW'(1);
  localparam logic [CW-1:0] c_cnt_full = CW'(DEPTH);
  localparam logic [PW-1:0] c_ptr_one  = PW'(1);

  logic [PW-1:0] r_wptr  [NCH];
  logic [PW-1:0] r_rptr  [NCH];
  logic [CW-1:0] r_cnt   [NCH];
  logic [NCH-1:0] r_phase;
  logic          r_err;

  logic          w_wr_oh;
  logic [IW-1:0] w_wr_idx;
  logic          w_wr_ready;
  logic          w_rd_oh;
  logic [IW-1:0] w_rd_idx;
  logic          w_rd_nonempty;
  logic          w_rd_dual;
  logic          w_pop;
  logic          w_pop_fin;
  logic          w_err_ev;
  logic [NCH-1:0] w_acc;
  logic [NCH-1:0] w_pop_ch;
  logic [NCH-1:0] w_fin_ch;
  logic [NCH-1:0] w_drop;
  logic [NCH*TSW-1:0] w_head_lo;
  logic [NCH*TSW-1:0] w_head_hi;

  function automatic logic [IW-1:0] enc(input logic [NCH-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      if (v[k]) r = r | IW'(k);
    end
    return r;
  endfunction

  always_comb begin
    w_wr_oh  = $onehot(bus.wr_ch);
    w_wr_idx = enc(bus.wr_ch);
`ifdef GPTP_RXBUF_OVERWRITE_EN
    w_wr_ready = w_wr_oh;
`else
    w_wr_ready = w_wr_oh && (r_cnt[w_wr_idx] != c_cnt_full);
`endif

    w_rd_oh       = $onehot(bus.rd_sel);
    w_rd_idx      = enc(bus.rd_sel);
    w_rd_nonempty = (r_cnt[w_rd_idx] != '0);
    w_rd_dual     = DUAL_MASK[w_rd_idx];

    // A dual entry only retires on its second pop.
    w_pop     = bus.rd_pop && w_rd_oh && w_rd_nonempty;
    w_pop_fin = w_pop && (!w_rd_dual || r_phase[w_rd_idx]);

    w_err_ev = (bus.wr_valid && !w_wr_oh) || (bus.rd_pop && !w_rd_oh);

    w_acc    = '0;
    w_pop_ch = '0;
    w_fin_ch = '0;
    w_drop   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_acc[k]    = bus.wr_valid && w_wr_ready && bus.wr_ch[k];
      w_pop_ch[k] = w_pop && bus.rd_sel[k];
      w_fin_ch[k] = w_pop_fin && bus.rd_sel[k];
`ifdef GPTP_RXBUF_OVERWRITE_EN
      // A final pop in the same cycle frees the slot, so nothing is lost.
      w_drop[k]   = w_acc[k] && (r_cnt[k] == c_cnt_full) && !w_fin_ch[k];
`endif
    end
  end

  always_comb begin
    bus.rd_data   = '0;
    bus.rd_second = w_rd_oh && r_phase[w_rd_idx];
    bus.rd_avail  = '0;
    cnt_o         = '0;
    for (int k = 0; k < NCH; k++) begin
      bus.rd_avail[k]    = (r_cnt[k] != '0);
      cnt_o[k*CW +: CW]  = r_cnt[k];
      if (w_rd_oh && w_rd_nonempty && bus.rd_sel[k]) begin
        bus.rd_data = (DUAL_MASK[k] && r_phase[k]) ? w_head_hi[k*TSW +: TSW]
                                                   : w_head_lo[k*TSW +: TSW];
      end
    end
  end

  assign bus.wr_ready = w_wr_ready;
  assign err_sticky   = r_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NCH; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
        r_cnt[k]  <= '0;
      end
      r_phase <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_acc[k]) r_wptr[k] <= r_wptr[k] + c_ptr_one;
        if (w_fin_ch[k] || w_drop[k]) r_rptr[k] <= r_rptr[k] + c_ptr_one;
        if (w_acc[k] && !w_fin_ch[k] && !w_drop[k]) begin
          r_cnt[k] <= r_cnt[k] + c_cnt_one;
        end else if (!w_acc[k] && w_fin_ch[k]) begin
          r_cnt[k] <= r_cnt[k] - c_cnt_one;
        end
        if (w_drop[k]) begin
          r_phase[k] <= 1'b0;
        end else if (w_pop_ch[k] && DUAL_MASK[k]) begin
          r_phase[k] <= !r_phase[k];
        end
      end
      r_err <= w_err_ev || (r_err && !clr_err);
    end
  end

`ifdef GPTP_RXBUF_OVERWRITE_EN
  logic r_drop;
  always_ff @(posedge clk) begin
    if (!reset) r_drop <= 1'b0;
    else        r_drop <= (|w_drop) || (r_drop && !clr_err);
  end
  assign drop_sticky = r_drop;
`else
  assign drop_sticky = 1'b0;
`endif

  // Storage is sized per channel: single-word channels keep only one TSW word.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    if (DUAL_MASK[i]) begin : g_dual
      logic [2*TSW-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (w_acc[i]) r_mem[r_wptr[i]] <= {bus.wr_data2, bus.wr_data1};
      end
      assign w_head_lo[i*TSW +: TSW] = r_mem[r_rptr[i]][TSW-1:0];
      assign w_head_hi[i*TSW +: TSW] = r_mem[r_rptr[i]][2*TSW-1:TSW];
    end else begin : g_single
      logic [TSW-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (w_acc[i]) r_mem[r_wptr[i]] <= WSEL_MASK[i] ? bus.wr_data2 : bus.wr_data1;
      end
      assign w_head_lo[i*TSW +: TSW] = r_mem[r_rptr[i]];
      assign w_head_hi[i*TSW +: TSW] = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gptp_rx_ts_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gptp_rx_ts_fifo : directed + random bench with word-queue model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gptp_rx_ts_fifo;
  localparam int NCH   = 8;
  localparam int TSW   = 80;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr_err = 1'b0;
  logic [NCH*CW-1:0] cnt_o;
  logic err_sticky;
  logic drop_sticky;

  logic [7:0] dual_m = 8'h08;
  logic [7:0] wsel_m = 8'h92;
  logic [7:0] one8   = 8'h01;

  int checks = 0;
  int failures = 0;

  // Model: each channel is a queue of words still to be read, in read order.
  logic [TSW-1:0] mq [NCH][$];
  logic m_err = 1'b0;
  logic m_drop = 1'b0;

  gptp_rx_ts_fifo_if #(.NCH(NCH), .TSW(TSW)) bus ();

  gptp_rx_ts_fifo #(.NCH(NCH), .TSW(TSW), .DEPTH(DEPTH),
                    .DUAL_MASK(8'h08), .WSEL_MASK(8'h92)) dut (
    .clk(clk), .reset(reset), .bus(bus), .clr_err(clr_err),
    .cnt_o(cnt_o), .err_sticky(err_sticky), .drop_sticky(drop_sticky)
  );

  always #5 clk = ~clk;

`ifdef GPTP_RXBUF_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  function automatic bit oh(input logic [7:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic int idx_of(input logic [7:0] v);
    for (int k = 0; k < NCH; k++) if (v[k]) return k;
    return 0;
  endfunction

  function automatic int m_cnt(input int ch);
    return dual_m[ch] ? (mq[ch].size() + 1) / 2 : mq[ch].size();
  endfunction

  function automatic logic [TSW-1:0] rand80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[TSW-1:0];
  endfunction

  function automatic bit exp_ready();
    if (!oh(bus.wr_ch)) return 1'b0;
    return OVW || (m_cnt(idx_of(bus.wr_ch)) < DEPTH);
  endfunction

  function automatic logic [TSW-1:0] exp_data();
    int i;
    if (!oh(bus.rd_sel)) return '0;
    i = idx_of(bus.rd_sel);
    if (mq[i].size() == 0) return '0;
    return mq[i][0];
  endfunction

  function automatic bit exp_second();
    int i;
    if (!oh(bus.rd_sel)) return 1'b0;
    i = idx_of(bus.rd_sel);
    return dual_m[i] && (mq[i].size() % 2 == 1);
  endfunction

  function automatic logic [7:0] exp_avail();
    logic [7:0] r;
    for (int k = 0; k < NCH; k++) r[k] = (m_cnt(k) != 0);
    return r;
  endfunction

  function automatic logic [NCH*CW-1:0] exp_cnt();
    logic [NCH*CW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*CW +: CW] = CW'(m_cnt(k));
    return r;
  endfunction

  // Applies one clock of the rules to the model using the current inputs.
  task automatic model_step();
    bit acc, ev, dropped;
    int wi, ri;
    if (!reset) begin
      for (int k = 0; k < NCH; k++) mq[k].delete();
      m_err = 1'b0;
      m_drop = 1'b0;
      return;
    end
    acc = bus.wr_valid && exp_ready();
    ev  = (bus.wr_valid && !oh(bus.wr_ch)) || (bus.rd_pop && !oh(bus.rd_sel));
    dropped = 1'b0;
    if (bus.rd_pop && oh(bus.rd_sel)) begin
      ri = idx_of(bus.rd_sel);
      if (mq[ri].size() > 0) void'(mq[ri].pop_front());
    end
    if (acc) begin
      wi = idx_of(bus.wr_ch);
      if (m_cnt(wi) == DEPTH) begin
        dropped = 1'b1;
        void'(mq[wi].pop_front());
        if (dual_m[wi] && (mq[wi].size() % 2 == 1)) void'(mq[wi].pop_front());
      end
      if (dual_m[wi]) begin
        mq[wi].push_back(bus.wr_data1);
        mq[wi].push_back(bus.wr_data2);
      end else begin
        mq[wi].push_back(wsel_m[wi] ? bus.wr_data2 : bus.wr_data1);
      end
    end
    m_err  = ev ? 1'b1 : (clr_err ? 1'b0 : m_err);
    m_drop = dropped ? 1'b1 : (clr_err ? 1'b0 : m_drop);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0;
    bus.wr_ch    = '0;
    bus.rd_pop   = 1'b0;
    bus.rd_sel   = '0;
    clr_err      = 1'b0;
  endtask

  task automatic write(input logic [7:0] ch, input logic [TSW-1:0] d1, input logic [TSW-1:0] d2);
    bus.wr_valid = 1'b1;
    bus.wr_ch    = ch;
    bus.wr_data1 = d1;
    bus.wr_data2 = d2;
    tick();
    idle();
  endtask

  task automatic pop(input logic [7:0] ch);
    bus.rd_sel = ch;
    bus.rd_pop = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    settle();
    checks++; if (bus.rd_avail !== 8'h00) begin failures++; $display("FAIL reset_avail got=%h exp=00", bus.rd_avail); end
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt_o); end
    checks++; if (err_sticky !== 1'b0 || drop_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b%b exp=00", err_sticky, drop_sticky); end
    checks++; if (bus.rd_second !== 1'b0 || bus.rd_data !== '0) begin failures++; $display("FAIL reset_rd got=%b/%h exp=0/0", bus.rd_second, bus.rd_data); end
  endtask

  task automatic test_single();
    bus.wr_valid = 1'b1; bus.wr_ch = 8'h04; bus.wr_data1 = 80'h1234; bus.wr_data2 = rand80();
    settle();
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", bus.wr_ready); end
    tick(); idle(); settle();
    checks++; if (bus.rd_avail !== 8'h04) begin failures++; $display("FAIL single_avail got=%h exp=04", bus.rd_avail); end
    bus.rd_sel = 8'h04; settle();
    checks++; if (bus.rd_data !== 80'h1234) begin failures++; $display("FAIL single_data got=%h exp=1234", bus.rd_data); end
    pop(8'h04); settle();
    checks++; if (bus.rd_avail !== 8'h00) begin failures++; $display("FAIL single_empty got=%h exp=00", bus.rd_avail); end
  endtask

  task automatic test_dual();
    write(8'h08, 80'hA, 80'hB);
    bus.rd_sel = 8'h08; settle();
    checks++; if (bus.rd_data !== 80'hA || bus.rd_second !== 1'b0) begin failures++; $display("FAIL dual_w1 got=%h/%b exp=a/0", bus.rd_data, bus.rd_second); end
    checks++; if (cnt_o[3*CW +: CW] !== 3'd1) begin failures++; $display("FAIL dual_cnt1 got=%0d exp=1", cnt_o[3*CW +: CW]); end
    pop(8'h08); bus.rd_sel = 8'h08; settle();
    checks++; if (bus.rd_data !== 80'hB || bus.rd_second !== 1'b1) begin failures++; $display("FAIL dual_w2 got=%h/%b exp=b/1", bus.rd_data, bus.rd_second); end
    pop(8'h08); settle();
    checks++; if (cnt_o[3*CW +: CW] !== 3'd0 || bus.rd_avail !== 8'h00) begin failures++; $display("FAIL dual_empty got=%0d/%h exp=0/00", cnt_o[3*CW +: CW], bus.rd_avail); end
  endtask

  task automatic test_fill_wrap();
    for (int v = 1; v <= 4; v++) write(8'h01, TSW'(v), rand80());
    bus.wr_valid = 1'b1; bus.wr_ch = 8'h01; settle();
    checks++; if (bus.wr_ready !== OVW) begin failures++; $display("FAIL full_ready got=%b exp=%b", bus.wr_ready, OVW); end
    bus.wr_ch = 8'h20; bus.wr_data1 = 80'h55; settle();
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL other_ready got=%b exp=1", bus.wr_ready); end
    tick(); idle();
    for (int r = 0; r < 2; r++) begin
      for (int v = 1; v <= 4; v++) begin
        bus.rd_sel = 8'h01; settle();
        checks++; if (bus.rd_data !== TSW'(v + 4*r)) begin failures++; $display("FAIL fifo_order got=%h exp=%h", bus.rd_data, TSW'(v + 4*r)); end
        pop(8'h01);
      end
      if (r == 0) for (int v = 5; v <= 8; v++) write(8'h01, TSW'(v), rand80());
    end
    bus.rd_sel = 8'h20; settle();
    checks++; if (bus.rd_data !== 80'h55) begin failures++; $display("FAIL ch5_data got=%h exp=55", bus.rd_data); end
    pop(8'h20);
  endtask

  task automatic test_full_pushpop();
    for (int v = 0; v < 4; v++) write(8'h01, rand80(), rand80());
    bus.wr_valid = 1'b1; bus.wr_ch = 8'h01; bus.wr_data1 = rand80();
    bus.rd_sel = 8'h01; bus.rd_pop = 1'b1; settle();
    checks++; if (bus.wr_ready !== OVW) begin failures++; $display("FAIL pp_full_ready got=%b exp=%b", bus.wr_ready, OVW); end
    tick(); idle(); settle();
    checks++; if (cnt_o[0 +: CW] !== (OVW ? 3'd4 : 3'd3)) begin failures++; $display("FAIL pp_full_cnt got=%0d exp=%0d", cnt_o[0 +: CW], OVW ? 4 : 3); end
    while (m_cnt(0) > 2) pop(8'h01);
    bus.wr_valid = 1'b1; bus.wr_ch = 8'h01; bus.wr_data1 = rand80();
    bus.rd_sel = 8'h01; bus.rd_pop = 1'b1;
    tick(); idle(); settle();
    checks++; if (cnt_o[0 +: CW] !== 3'd2) begin failures++; $display("FAIL pp_cnt2 got=%0d exp=2", cnt_o[0 +: CW]); end
    while (m_cnt(0) > 0) begin
      bus.rd_sel = 8'h01; settle();
      checks++; if (bus.rd_data !== exp_data()) begin failures++; $display("FAIL pp_drain got=%h exp=%h", bus.rd_data, exp_data()); end
      pop(8'h01);
    end
  endtask

  task automatic test_errors();
    bus.wr_valid = 1'b1; bus.wr_ch = 8'h06; bus.wr_data1 = rand80();
    tick(); idle(); settle();
    checks++; if (err_sticky !== 1'b1 || bus.rd_avail !== 8'h00) begin failures++; $display("FAIL err_wr got=%b/%h exp=1/00", err_sticky, bus.rd_avail); end
    clr_err = 1'b1; tick(); idle(); settle();
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", err_sticky); end
    bus.rd_sel = 8'h00; bus.rd_pop = 1'b1; tick(); idle(); settle();
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL err_rd got=%b exp=1", err_sticky); end
    clr_err = 1'b1; bus.wr_valid = 1'b1; bus.wr_ch = 8'h00; tick(); idle(); settle();
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL err_wins got=%b exp=1", err_sticky); end
    clr_err = 1'b1; tick(); idle();
  endtask

  task automatic test_overwrite();
    for (int v = 1; v <= 5; v++) write(8'h02, rand80(), TSW'(v));
    settle();
    checks++; if (drop_sticky !== OVW) begin failures++; $display("FAIL ovw_drop got=%b exp=%b", drop_sticky, OVW); end
    while (m_cnt(1) > 0) begin
      bus.rd_sel = 8'h02; settle();
      checks++; if (bus.rd_data !== exp_data()) begin failures++; $display("FAIL ovw_order got=%h exp=%h", bus.rd_data, exp_data()); end
      pop(8'h02);
    end
    clr_err = 1'b1; tick(); idle();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 800; n++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      if (r == 0)      bus.wr_ch = 8'h00;
      else if (r == 1) bus.wr_ch = 8'($urandom());
      else             bus.wr_ch = one8 << $urandom_range(0, 7);
      bus.wr_data1 = rand80();
      bus.wr_data2 = rand80();
      bus.rd_sel   = ($urandom_range(0, 15) == 0) ? 8'h00 : (one8 << $urandom_range(0, 7));
      bus.rd_pop   = 1'($urandom_range(0, 1));
      clr_err      = ($urandom_range(0, 15) == 0);
      settle();
      checks++; if (bus.wr_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.wr_ready, exp_ready()); end
      checks++; if (bus.rd_avail !== exp_avail() || cnt_o !== exp_cnt()) begin failures++; $display("FAIL rnd_occ n=%0d got=%h/%h exp=%h/%h", n, bus.rd_avail, cnt_o, exp_avail(), exp_cnt()); end
      checks++; if (bus.rd_data !== exp_data()) begin failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, bus.rd_data, exp_data()); end
      checks++; if (err_sticky !== m_err || drop_sticky !== m_drop) begin failures++; $display("FAIL rnd_sticky n=%0d got=%b%b exp=%b%b", n, err_sticky, drop_sticky, m_err, m_drop); end
      if (oh(bus.rd_sel)) begin
        checks++; if (bus.rd_second !== exp_second()) begin failures++; $display("FAIL rnd_second n=%0d got=%b exp=%b", n, bus.rd_second, exp_second()); end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    bus.wr_data1 = '0;
    bus.wr_data2 = '0;
    idle();
    test_reset();
    test_single();
    test_dual();
    test_fill_wrap();
    test_full_pushpop();
    test_errors();
    test_overwrite();
    test_random();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
